// File: rtl/sync_multi.sv
// -----------------------------------------------------------------------------
// sync_multi
//   Multi-channel pending/select handshake synchroniser. Each channel waits for
//   a request level (pending), then for the start of the next complete bus slot
//   (select). On that slot it issues one strobe clock and then holds done until
//   the requester drops pending. A per-channel watchdog moves a channel to an
//   error state if no slot arrives within TIMEOUT clocks.
//
// Handshake: pending is a level held by the requester for the whole
//   transaction. strobe is combinational (select & PENDING) and lasts exactly
//   one clock. done/error are decodes of registered state and stay high until
//   pending falls. Dropping pending returns the channel to IDLE on the next
//   edge from any state.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   pending  in   [CHANNELS] per-channel request level
//   select   in   [CHANNELS] per-channel bus-slot indicator
//   strobe   out  [CHANNELS] per-channel one-clock access strobe
//   done     out  [CHANNELS] per-channel completion level
//   error    out  [CHANNELS] per-channel watchdog timeout level
//   busy     out  high while any channel is in PENDING
// -----------------------------------------------------------------------------
module sync_multi #(
  parameter int CHANNELS      = 4,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT       = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pending,
  input  logic [CHANNELS-1:0] select,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] error,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  // Counter value on which the watchdog fires (value before the TIMEOUT-th
  // edge after entering PENDING). Meaningless when TIMEOUT is 0; guarded below.
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic                     WD_ON    = (TIMEOUT != 0);

  logic [CHANNELS-1:0] in_pending;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!pending[i]) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Never start mid-slot: only arm once select is low.
            if (!select[i]) begin
              state_d = ST_PENDING;
              cnt_d   = '0;
            end
          end
          ST_PENDING: begin
            // A slot arriving on the timeout edge still completes normally.
            if (select[i]) begin
              state_d = ST_DONE;
            end else if (WD_ON && (cnt_q == CNT_LAST)) begin
              state_d = ST_ERROR;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
            end
          end
          ST_DONE:  state_d = ST_DONE;
          ST_ERROR: state_d = ST_ERROR;
          default:  state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign in_pending[i] = (state_q == ST_PENDING);
    assign strobe[i]     = select[i] & in_pending[i];
    assign done[i]       = (state_q == ST_DONE);
    assign error[i]      = (state_q == ST_ERROR);
  end

  assign busy = |in_pending;

endmodule

// File: tb/tb_sync_multi.sv
// -----------------------------------------------------------------------------
// tb_sync_multi
//   Directed bench for sync_multi with CHANNELS=4, TIMEOUT=8. Inputs change
//   1 time unit after each rising edge; outputs are checked 1 unit later, well
//   before the next edge, so combinational strobe reflects the new select.
// -----------------------------------------------------------------------------
module tb_sync_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pending;
  logic [3:0] select;
  logic [3:0] strobe;
  logic [3:0] done;
  logic [3:0] error;
  logic       busy;

  int checks = 0;
  int passed = 0;

  sync_multi #(
    .CHANNELS      (4),
    .TIMEOUT_WIDTH (8),
    .TIMEOUT       (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pending (pending),
    .select  (select),
    .strobe  (strobe),
    .done    (done),
    .error   (error),
    .busy    (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p, input logic [3:0] s);
    pending = p;
    select  = s;
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [3:0] s, input logic [3:0] d,
                           input logic [3:0] e, input logic b);
    check({tag, ".strobe"}, strobe, s);
    check({tag, ".done"},   done,   d);
    check({tag, ".error"},  error,  e);
    check({tag, ".busy"},   {3'b000, busy}, {3'b000, b});
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000);
    cyc();
    cyc();
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;

    // Basic: ch0 pending, three select-low clocks, then a two-clock slot.
    drive(4'b0001, 4'b0000);
    check_all("basic.idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc();
    check_all("basic.pend", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    cyc();
    cyc();
    drive(4'b0001, 4'b0001);
    check_all("basic.strobe", 4'b0001, 4'b0000, 4'b0000, 1'b1);
    cyc();
    check_all("basic.done", 4'b0000, 4'b0001, 4'b0000, 1'b0);
    cyc();
    drive(4'b0001, 4'b0000);
    check_all("basic.hold", 4'b0000, 4'b0001, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000);
    cyc();
    check_all("basic.release", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Mid-slot start: ch1 requests while its slot is already running.
    drive(4'b0010, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_all("midslot.wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    drive(4'b0010, 4'b0000);
    cyc();
    check_all("midslot.pend", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    cyc();
    drive(4'b0010, 4'b0010);
    check_all("midslot.strobe", 4'b0010, 4'b0000, 4'b0000, 1'b1);
    cyc();
    check_all("midslot.done", 4'b0000, 4'b0010, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000);
    cyc();
    check_all("midslot.release", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Timeout: ch2 never sees a slot; error on the 8th edge after entry.
    drive(4'b0100, 4'b0000);
    cyc();
    check_all("tmo.enter", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int k = 1; k < 8; k++) begin
      cyc();
      check_all("tmo.count", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    end
    cyc();
    check_all("tmo.error", 4'b0000, 4'b0000, 4'b0100, 1'b0);
    cyc();
    check_all("tmo.errhold", 4'b0000, 4'b0000, 4'b0100, 1'b0);
    drive(4'b0000, 4'b0000);
    cyc();
    check_all("tmo.release", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Select arriving on the timeout edge wins.
    drive(4'b0100, 4'b0000);
    cyc();
    for (int k = 1; k < 8; k++) cyc();
    drive(4'b0100, 4'b0100);
    check_all("tmo.race.strobe", 4'b0100, 4'b0000, 4'b0000, 1'b1);
    cyc();
    check_all("tmo.race.done", 4'b0000, 4'b0100, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000);
    cyc();

    // Reset mid-operation: ch0 PENDING, ch3 DONE.
    drive(4'b1001, 4'b0000);
    cyc();
    drive(4'b1001, 4'b1000);
    cyc();
    drive(4'b1001, 4'b0000);
    check_all("rst.pre", 4'b0000, 4'b1000, 4'b0000, 1'b1);
    reset = 1'b1;
    cyc();
    check_all("rst.during", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    cyc();
    check_all("rst.reenter", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    drive(4'b1001, 4'b1001);
    check_all("rst.strobe", 4'b1001, 4'b0000, 4'b0000, 1'b1);
    cyc();
    check_all("rst.done", 4'b0000, 4'b1001, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000);
    cyc();

    // Concurrency: slots in order 3,1,0,2.
    drive(4'b1111, 4'b0000);
    cyc();
    check_all("conc.pend", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    drive(4'b1111, 4'b1000);
    check_all("conc.s3", 4'b1000, 4'b0000, 4'b0000, 1'b1);
    cyc();
    drive(4'b1111, 4'b0010);
    check_all("conc.s1", 4'b0010, 4'b1000, 4'b0000, 1'b1);
    cyc();
    drive(4'b1111, 4'b0001);
    check_all("conc.s0", 4'b0001, 4'b1010, 4'b0000, 1'b1);
    cyc();
    drive(4'b1111, 4'b0100);
    check_all("conc.s2", 4'b0100, 4'b1011, 4'b0000, 1'b1);
    cyc();
    check_all("conc.alldone", 4'b0000, 4'b1111, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000);
    cyc();
    check_all("conc.release", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Cancel: ch1 dropped at cnt=5, re-raised two clocks later.
    drive(4'b0010, 4'b0000);
    cyc();
    for (int k = 0; k < 5; k++) cyc();
    check_all("cancel.pend", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    drive(4'b0000, 4'b0000);
    cyc();
    check_all("cancel.idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc();
    drive(4'b0010, 4'b0000);
    cyc();
    check_all("cancel.reenter", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int k = 1; k < 8; k++) begin
      cyc();
      check_all("cancel.count", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    end
    cyc();
    check_all("cancel.error", 4'b0000, 4'b0000, 4'b0010, 1'b0);
    drive(4'b0000, 4'b0000);
    cyc();
    check_all("cancel.release", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
